// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues a start bit, then shifts one
// command byte plus odd parity out on device clock edges and reports ack/no-ack/timeout.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int START_TIMEOUT  = 1500000,
  parameter int FRAME_TIMEOUT  = 200000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       busy,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       done,
  output logic       ack_ok,
  output logic       err_noack,
  output logic       err_timeout
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_INHIBIT   = 3'd1;
  localparam logic [2:0] ST_REQ       = 3'd2;
  localparam logic [2:0] ST_DATA      = 3'd3;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd4;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  logic [2:0]  state_r;
  logic [31:0] cnt_r;
  logic [3:0]  bit_cnt_r;
  logic [7:0]  data_r;
  logic        par_r;
  logic        ack_res_r;
  logic        clk_s1_r, clk_s2_r, clk_prev_r;
  logic        data_s1_r, data_s2_r;
  logic        clk_oe_r, data_oe_r;
  logic        done_r, ack_ok_r, err_noack_r, err_timeout_r;

  logic        fall_s;
  logic [3:0]  k_next_s;
  logic [2:0]  bit_idx_s;
  logic        frame_bit_s;

  assign fall_s      = clk_prev_r & ~clk_s2_r;
  assign tx_ready    = (state_r == ST_IDLE) && !reset;
  assign busy        = (state_r != ST_IDLE);
  assign ps2_clk_oe  = clk_oe_r;
  assign ps2_data_oe = data_oe_r;
  assign done        = done_r;
  assign ack_ok      = ack_ok_r;
  assign err_noack   = err_noack_r;
  assign err_timeout = err_timeout_r;

  // Line drive for the falling edge about to be counted (oe=1 pulls the line low).
  always_comb begin
    k_next_s    = bit_cnt_r + 4'd1;
    bit_idx_s   = k_next_s[2:0] - 3'd1;
    frame_bit_s = 1'b0;
    if (k_next_s <= 4'd8) begin
      frame_bit_s = ~data_r[bit_idx_s];
    end else if (k_next_s == 4'd9) begin
      frame_bit_s = ~par_r;
    end else begin
      frame_bit_s = 1'b0;
    end
  end

  // Synchronizers, transfer FSM, line drivers and result flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      cnt_r         <= 32'd0;
      bit_cnt_r     <= 4'd0;
      data_r        <= 8'd0;
      par_r         <= 1'b0;
      ack_res_r     <= 1'b0;
      clk_s1_r      <= 1'b1;
      clk_s2_r      <= 1'b1;
      clk_prev_r    <= 1'b1;
      data_s1_r     <= 1'b1;
      data_s2_r     <= 1'b1;
      clk_oe_r      <= 1'b0;
      data_oe_r     <= 1'b0;
      done_r        <= 1'b0;
      ack_ok_r      <= 1'b0;
      err_noack_r   <= 1'b0;
      err_timeout_r <= 1'b0;
    end else begin
      clk_s1_r      <= ps2_clk_in;
      clk_s2_r      <= clk_s1_r;
      clk_prev_r    <= clk_s2_r;
      data_s1_r     <= ps2_data_in;
      data_s2_r     <= data_s1_r;
      done_r        <= 1'b0;
      ack_ok_r      <= 1'b0;
      err_noack_r   <= 1'b0;
      err_timeout_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          clk_oe_r  <= 1'b0;
          data_oe_r <= 1'b0;
          if (tx_valid) begin
            data_r    <= tx_data;
            par_r     <= odd_parity(tx_data);
            bit_cnt_r <= 4'd0;
            cnt_r     <= 32'(INHIBIT_CYCLES - 1);
            clk_oe_r  <= 1'b1;
            data_oe_r <= (INHIBIT_CYCLES == 1);
            state_r   <= ST_INHIBIT;
          end
        end
        ST_INHIBIT: begin
          if (cnt_r == 32'd0) begin
            clk_oe_r  <= 1'b0;
            data_oe_r <= 1'b1;
            cnt_r     <= 32'(START_TIMEOUT);
            state_r   <= ST_REQ;
          end else begin
            cnt_r <= cnt_r - 32'd1;
            if (cnt_r == 32'd1) begin
              data_oe_r <= 1'b1;
            end
          end
        end
        ST_REQ, ST_DATA: begin
          // A device edge takes priority over an expiring timer in the same cycle.
          if (fall_s) begin
            bit_cnt_r <= k_next_s;
            if (state_r == ST_REQ) begin
              cnt_r   <= 32'(FRAME_TIMEOUT);
              state_r <= ST_DATA;
            end else if (cnt_r != 32'd0) begin
              cnt_r <= cnt_r - 32'd1;
            end
            if (k_next_s == 4'd11) begin
              ack_res_r <= ~data_s2_r;
              clk_oe_r  <= 1'b0;
              data_oe_r <= 1'b0;
              state_r   <= ST_WAIT_IDLE;
            end else begin
              data_oe_r <= frame_bit_s;
            end
          end else if (cnt_r == 32'd0) begin
            clk_oe_r      <= 1'b0;
            data_oe_r     <= 1'b0;
            done_r        <= 1'b1;
            err_timeout_r <= 1'b1;
            state_r       <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r - 32'd1;
          end
        end
        ST_WAIT_IDLE: begin
          clk_oe_r  <= 1'b0;
          data_oe_r <= 1'b0;
          if (clk_s2_r && data_s2_r) begin
            done_r      <= 1'b1;
            ack_ok_r    <= ack_res_r;
            err_noack_r <= ~ack_res_r;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          clk_oe_r  <= 1'b0;
          data_oe_r <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
